// File: rtl/count_pwm_pkg.sv
// count_pwm_pkg: shared types and constants for the counter-driven PWM generator.
//   pwm_state_e : FSM encoding (IDLE, PENDING, RUN)
//   CNT_W_DEF   : default counter width
//   PCNT_W_DEF  : default completed-period counter width
//   duty_full() : full-scale duty (2^cnt_w), the "always high" setting
package count_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    RUN     = 2'd2
  } pwm_state_e;

  localparam int unsigned CNT_W_DEF  = 4;
  localparam int unsigned PCNT_W_DEF = 8;

  function automatic int unsigned duty_full(input int unsigned cnt_w);
    return 32'd1 << cnt_w;
  endfunction

endpackage

// File: rtl/count_pwm_gen.sv
// count_pwm_gen: PWM generator driven by an external free-running up-counter.
// A duty request is taken over valid/ready into a shadow register and applied
// only at a period boundary (cnt_in all ones), so every period is whole.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   enable            run control; low returns the FSM to IDLE
//   cnt_in            counter value, one period = 2^CNT_W cycles
//   duty_in/valid     requested high time 0..2^CNT_W (larger values saturate)
//   duty_ready        combinational, low only while a duty is pending
//   pwm_out           registered PWM, one cycle behind cnt_in
//   duty_active       duty currently in effect
//   period_cnt        completed periods while running (wraps)
//   busy              high while a duty is pending
// Optional build macro COUNT_PWM_IRQ_EN adds irq (sticky, set when a pending
// duty is applied) and irq_clr (clear; a simultaneous set wins).
module count_pwm_gen
  import count_pwm_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PCNT_W = PCNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic [CNT_W:0]    duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic [CNT_W:0]    duty_active,
  output logic [PCNT_W-1:0] period_cnt,
  output logic              busy
`ifdef COUNT_PWM_IRQ_EN
  ,
  input  logic              irq_clr,
  output logic              irq
`endif
);

  localparam int unsigned DUTY_W = CNT_W + 1;
  localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(duty_full(CNT_W));
  localparam logic [CNT_W-1:0]  CNT_LAST  = '1;

  pwm_state_e r_state;
  pwm_state_e w_state_nxt;

  logic [DUTY_W-1:0] r_shadow;
  logic [DUTY_W-1:0] r_duty_active;
  logic [DUTY_W-1:0] w_duty_sat;
  logic [PCNT_W-1:0] r_period_cnt;
  logic              r_pwm;
  logic              r_busy;
  logic              r_from_idle;

  logic w_period_end;
  logic w_ready;
  logic w_accept;
  logic w_apply;
  logic w_cmp_en;
  logic w_pwm_nxt;

  assign w_period_end = (cnt_in == CNT_LAST);
  assign w_duty_sat   = (duty_in > DUTY_FULL) ? DUTY_FULL : duty_in;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; enable low overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept)     w_state_nxt = PENDING;
        PENDING: if (w_period_end) w_state_nxt = RUN;
        RUN:     if (w_accept)     w_state_nxt = PENDING;
        default:                   w_state_nxt = IDLE;
      endcase
    end
  end

  // Output decode. A PENDING entered from IDLE has no duty in effect yet,
  // so its compare stays disabled until the first apply.
  always_comb begin
    w_ready  = 1'b1;
    w_apply  = 1'b0;
    w_cmp_en = 1'b0;
    case (r_state)
      IDLE: w_ready = 1'b1;
      PENDING: begin
        w_ready  = 1'b0;
        w_apply  = enable & w_period_end;
        w_cmp_en = ~r_from_idle;
      end
      RUN:     w_cmp_en = 1'b1;
      default: w_ready  = 1'b1;
    endcase
    w_accept  = duty_valid & w_ready & enable;
    w_pwm_nxt = enable & w_cmp_en & ({1'b0, cnt_in} < r_duty_active);
  end

  // Datapath registers: shadow, active duty, period counter, outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow      <= '0;
      r_duty_active <= '0;
      r_period_cnt  <= '0;
      r_pwm         <= 1'b0;
      r_busy        <= 1'b0;
      r_from_idle   <= 1'b0;
    end else begin
      r_pwm  <= w_pwm_nxt;
      r_busy <= (w_state_nxt == PENDING);
      if (w_accept) begin
        r_shadow    <= w_duty_sat;
        r_from_idle <= (r_state == IDLE);
      end else if (!enable) begin
        // dropping enable discards any pending duty
        r_shadow <= '0;
      end
      if (w_apply) begin
        r_duty_active <= r_shadow;
      end
      if ((r_state == RUN) && w_period_end) begin
        r_period_cnt <= r_period_cnt + PCNT_W'(1);
      end
    end
  end

  assign duty_ready  = w_ready;
  assign pwm_out     = r_pwm;
  assign duty_active = r_duty_active;
  assign period_cnt  = r_period_cnt;
  assign busy        = r_busy;

`ifdef COUNT_PWM_IRQ_EN
  logic r_irq;

  // Sticky apply interrupt; set has priority over clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else if (w_apply) begin
      r_irq <= 1'b1;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_count_pwm_gen.sv
// tb_count_pwm_gen: directed bench for count_pwm_gen. The bench owns the
// free-running 4-bit counter that feeds cnt_in and checks pwm patterns,
// duty/state outputs and period counts against hand-computed values.
module tb_count_pwm_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] cnt;
  logic [4:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic [4:0] duty_active;
  logic [7:0] period_cnt;
  logic       busy;
`ifdef COUNT_PWM_IRQ_EN
  logic       irq_clr;
  logic       irq;
`endif

  int n_tot = 0;
  int n_bad = 0;

  count_pwm_gen #(.CNT_W(4), .PCNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cnt_in      (cnt),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm_out     (pwm_out),
    .duty_active (duty_active),
    .period_cnt  (period_cnt),
    .busy        (busy)
`ifdef COUNT_PWM_IRQ_EN
    ,
    .irq_clr     (irq_clr),
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  // Upstream free-running counter sharing the reset
  always @(posedge clk or posedge reset) begin
    if (reset) cnt <= 4'd0;
    else       cnt <= cnt + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_cnt(input logic [3:0] v);
    for (int i = 0; i < 40 && cnt != v; i++) step();
  endtask

  task automatic send(input logic [4:0] d);
    duty_in    = d;
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
  endtask

  // Send a duty, then run to the boundary edge that applies it
  task automatic send_apply(input logic [4:0] d);
    send(d);
    wait_cnt(4'd15);
    step();
  endtask

  // One full period of pwm_out, bit i = output after the edge that saw cnt=i
  task automatic capture(output logic [15:0] pat);
    pat = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      pat[i] = pwm_out;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] pat;
    int          n_hi;
    int          n_nrdy;

    reset      = 1'b0;
    enable     = 1'b1;
    duty_in    = 5'd0;
    duty_valid = 1'b0;
`ifdef COUNT_PWM_IRQ_EN
    irq_clr    = 1'b0;
`endif
    #2 reset = 1'b1;
    #2;
    chk("rst_pwm", pwm_out, 0);
    chk("rst_duty", duty_active, 0);
    chk("rst_pcnt", period_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", duty_ready, 1);
`ifdef COUNT_PWM_IRQ_EN
    chk("rst_irq", irq, 0);
`endif
    step();
    reset = 1'b0;

    // 1: enabled, no duty ever sent
    n_hi = 0;
    n_nrdy = 0;
    repeat (40) begin
      step();
      n_hi   += int'(pwm_out);
      n_nrdy += int'(!duty_ready);
    end
    chk("t1_pwm_hi", n_hi, 0);
    chk("t1_not_ready", n_nrdy, 0);
    chk("t1_pcnt", period_cnt, 0);

    // 2: duty 5 from reset
    do_reset();
    send(5'd5);
    chk("t2_busy", busy, 1);
    chk("t2_ready", duty_ready, 0);
    chk("t2_pwm_pend", pwm_out, 0);
    wait_cnt(4'd15);
    chk("t2_busy_c15", busy, 1);
    step();
    chk("t2_busy_run", busy, 0);
    chk("t2_duty", duty_active, 5);
    chk("t2_ready_run", duty_ready, 1);
    capture(pat);
    chk("t2_pat1", pat, 16'h001F);
    chk("t2_pcnt1", period_cnt, 1);
    capture(pat);
    chk("t2_pat2", pat, 16'h001F);
    chk("t2_pcnt2", period_cnt, 2);

    // 3: duty 12 accepted on the cnt=15 edge waits a full period
    wait_cnt(4'd15);
    send(5'd12);
    chk("t3_busy", busy, 1);
    chk("t3_duty_old", duty_active, 5);
    chk("t3_pcnt", period_cnt, 3);
    capture(pat);
    chk("t3_pat_old", pat, 16'h001F);
    chk("t3_duty_new", duty_active, 12);
    chk("t3_pcnt_pend", period_cnt, 3);
    capture(pat);
    chk("t3_pat_new", pat, 16'h0FFF);
    chk("t3_pcnt_run", period_cnt, 4);

    // 4: boundary duties and saturation
    send_apply(5'd0);
    chk("t4_duty0", duty_active, 0);
    capture(pat);
    chk("t4_pat0", pat, 16'h0000);
    send_apply(5'd16);
    chk("t4_duty16", duty_active, 16);
    capture(pat);
    chk("t4_pat16", pat, 16'hFFFF);
    send_apply(5'd31);
    chk("t4_duty31_sat", duty_active, 16);
    capture(pat);
    chk("t4_pat31", pat, 16'hFFFF);
    chk("t4_pcnt", period_cnt, 7);

    // 5: enable dropped while duty 9 is pending
    send(5'd9);
    chk("t5_busy", busy, 1);
    chk("t5_pwm_before", pwm_out, 1);
    enable = 1'b0;
    step();
    chk("t5_pwm_off", pwm_out, 0);
    chk("t5_busy_off", busy, 0);
    n_hi = 0;
    repeat (20) begin
      step();
      n_hi += int'(pwm_out);
    end
    chk("t5_pwm_dis_hi", n_hi, 0);
    enable = 1'b1;
    n_hi = 0;
    repeat (40) begin
      step();
      n_hi += int'(pwm_out);
    end
    chk("t5_pwm_idle_hi", n_hi, 0);
    chk("t5_duty_kept", duty_active, 16);
    chk("t5_pcnt_kept", period_cnt, 7);
    chk("t5_ready", duty_ready, 1);

    // 6: duty 7 running, then asynchronous reset mid-period
    send_apply(5'd7);
    chk("t6_duty", duty_active, 7);
`ifdef COUNT_PWM_IRQ_EN
    chk("t6_irq_set", irq, 1);
`endif
    capture(pat);
    chk("t6_pat7", pat, 16'h007F);
    chk("t6_pcnt", period_cnt, 8);
    step();
    step();
    step();
    chk("t6_pwm_mid", pwm_out, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_pwm", pwm_out, 0);
    chk("t6_rst_duty", duty_active, 0);
    chk("t6_rst_pcnt", period_cnt, 0);
    chk("t6_rst_busy", busy, 0);
`ifdef COUNT_PWM_IRQ_EN
    chk("t6_rst_irq", irq, 0);
`endif
    step();
    reset = 1'b0;
    send_apply(5'd3);
    capture(pat);
    chk("t6_pat3", pat, 16'h0007);
`ifdef COUNT_PWM_IRQ_EN
    chk("t6_irq_apply", irq, 1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("t6_irq_clr", irq, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/count_pwm_gen.md
Name: count_pwm_gen

Overview:
- Downstream consumer of the free-running 4-bit up-counter (async active-high reset, +1 per clk, wraps 15->0).
- Compares the counter value against a programmed duty to generate a PWM waveform whose period is one counter cycle.
- Duty updates arrive over a valid/ready handshake. They are held in a shadow register and take effect only at a period boundary, so no glitched or partial periods are produced.
- Also counts completed periods for software and test visibility.

Parameters:
- CNT_W, 4, width of the counter value input; period = 2^CNT_W clk cycles.
- PCNT_W, 8, width of the completed-period counter.

Ports:
- clk  input  1  rising-edge clock, same clock as the counter.
- reset  input  1  asynchronous, active-high.
- enable  input  1  run control; 0 forces IDLE.
- cnt_in  input  CNT_W  counter value (Q of the up-counter).
- duty_in  input  CNT_W+1  requested high-time in clk cycles, 0..2^CNT_W.
- duty_valid  input  1  duty_in is valid.
- duty_ready  output  1  block can accept duty_in.
- pwm_out  output  1  registered PWM output.
- duty_active  output  CNT_W+1  duty currently in effect.
- period_cnt  output  PCNT_W  completed periods while running; wraps modulo 2^PCNT_W.
- busy  output  1  high in PENDING.

Behaviour:
- Reset values: pwm_out=0, duty_active=0, shadow=0, period_cnt=0, state=IDLE, busy=0.
- duty_ready is combinational: 1 in IDLE and RUN, 0 in PENDING. Accept = duty_valid & duty_ready & enable.
- Saturation: duty_in > 2^CNT_W is saturated to 2^CNT_W when written to the shadow register.
- period_end = (cnt_in == all ones).
- FSM states: IDLE, PENDING, RUN.
- IDLE:
  - pwm_out driven 0.
  - On accept: shadow <= duty_in, go to PENDING.
- PENDING:
  - Continues the previous duty_active, or 0 if entered from IDLE.
  - On period_end: duty_active <= shadow, go to RUN.
- RUN:
  - On accept: shadow <= duty_in, go to PENDING.
  - An accept in the same cycle as period_end does NOT apply immediately; it applies at the next period_end.
- Compare and latency:
  - pwm_out <= (state != IDLE) & (cnt_in < duty_active), registered.
  - Latency is 1 clk from cnt_in to pwm_out.
  - The new duty is first compared when cnt_in==0, i.e. the cycle after the period_end that loaded it.
- Duty boundaries:
  - duty 0 -> pwm_out constantly 0.
  - duty 2^CNT_W -> pwm_out constantly 1.
  - duty d -> high for exactly d of every 2^CNT_W cycles.
- period_cnt increments on each period_end while state is RUN.
- enable falling to 0, in any state: next edge goes to IDLE, pwm_out 0, pending shadow discarded, duty_active and period_cnt retained.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), including any pending duty.
- Counter held in reset (cnt_in stuck at 0): no period_end occurs, so PENDING persists and pwm_out follows the current duty_active compare.

Optional Feature:
- Macro COUNT_PWM_IRQ_EN.
- Defined:
  - Adds output irq (1 bit) and input irq_clr (1 bit).
  - irq is set sticky at the period_end that moves PENDING->RUN (duty applied).
  - irq is cleared by irq_clr; set wins over a simultaneous clear.
  - irq resets to 0.
- Not defined: neither port exists and no logic is generated.

Decomposition:
- Shared package count_pwm_pkg:
  - state enum (IDLE, PENDING, RUN).
  - Default CNT_W and PCNT_W constants.
  - Function computing the full-scale duty 2^CNT_W.
- Sub-module: none required. The compare/output register may optionally be split into count_pwm_cmp, but the top stays the only FSM owner.

Test Plan:
1. Reset, enable=1, no duty sent -> pwm_out=0, duty_ready=1, period_cnt=0 for 40 cycles.
2. Send duty 5 with counter running from reset -> busy=1 and duty_ready=0 until cnt_in=15, then pwm_out high 5 cycles / low 11 per period; period_cnt increments once per 16 cycles.
3. In RUN at duty 5, send duty 12 on the cycle cnt_in=15 -> period in progress and next period stay at 5; duty 12 first appears in the period after next.
4. Duty 0 then duty 16, then duty 31 -> constant 0, constant 1, and duty_active=16 (saturated).
5. Drop enable while PENDING with duty 9 -> pwm_out 0 next cycle; re-enable shows duty_active still previous value and the shadow 9 never applied.
6. Assert reset mid-period with duty 7 running -> pwm_out, duty_active, period_cnt all 0 before the next clk edge; with COUNT_PWM_IRQ_EN, irq rises at the apply edge and clears on irq_clr.
